// File: rtl/isa_pkg.sv
// isa_pkg: 9-bit ISA definitions shared by encoder and decoder, plus the request encoder
package isa_pkg;
  typedef enum logic [2:0] {
    OP_STR, OP_LDR, OP_MOV, OP_SHIFT, OP_SADD, OP_JUMP, OP_XOR, OP_AND
  } opcode_t;
  typedef enum logic [4:0] {
    M_STR, M_LDR, M_MOV, M_SHR, M_SHL, M_ADD, M_SUB, M_COPY, M_ABS, M_CMP,
    M_BLE, M_BLT, M_BEQ, M_BNE, M_BGE, M_BGT, M_BR, M_BOF, M_ADD1, M_ADD2, M_SUB1,
    M_XOR, M_AND
  } mnemonic_t;
  localparam logic [1:0] SUB_ADD  = 2'd0;
  localparam logic [1:0] SUB_SUB  = 2'd1;
  localparam logic [1:0] SUB_COPY = 2'd2;
  localparam logic [1:0] SUB_ABS  = 2'd3;
  localparam logic [3:0] C_BLE  = 4'b0100;
  localparam logic [3:0] C_BLT  = 4'b0101;
  localparam logic [3:0] C_BEQ  = 4'b0110;
  localparam logic [3:0] C_BNE  = 4'b0111;
  localparam logic [3:0] C_BGE  = 4'b1000;
  localparam logic [3:0] C_BGT  = 4'b1010;
  localparam logic [3:0] C_BR   = 4'b1011;
  localparam logic [3:0] C_ADD1 = 4'b1100;
  localparam logic [3:0] C_ADD2 = 4'b1101;
  localparam logic [3:0] C_SUB1 = 4'b1110;
  localparam logic [3:0] C_BOF  = 4'b1111;
  typedef struct packed {
    logic       ok;
    logic [8:0] word;
  } enc_t;
  function automatic enc_t encode(input logic [4:0] kind, input logic [1:0] rd, ra, rb,
                                  input logic [3:0] imm);
    enc_t e;
    e.ok   = 1'b1;
    e.word = '0;
    case (kind)
      M_STR:  begin e.word = {OP_STR, rd, ra, imm[1:0]}; e.ok = imm <= 4'd3; end
      M_LDR:  begin e.word = {OP_LDR, rd, ra, imm[1:0]}; e.ok = imm <= 4'd3; end
      M_MOV:  e.word = {OP_MOV, rd, imm};
      M_SHR:  begin e.word = {OP_SHIFT, rd, imm}; e.ok = imm <= 4'd7; end
      // left shifts are encoded as a right rotate by 16-n
      M_SHL:  begin e.word = {OP_SHIFT, rd, 4'd0 - imm}; e.ok = imm != 4'd0 && imm <= 4'd8; end
      M_ADD:  e.word = {OP_SADD, SUB_ADD, ra, rb};
      M_SUB:  e.word = {OP_SADD, SUB_SUB, ra, rb};
      M_COPY: e.word = {OP_SADD, SUB_COPY, ra, rb};
      M_ABS:  e.word = {OP_SADD, SUB_ABS, ra, rb};
      M_CMP:  e.word = {OP_JUMP, 2'b00, ra, rb};
      M_BLE:  e.word = {OP_JUMP, C_BLE, rb};
      M_BLT:  e.word = {OP_JUMP, C_BLT, rb};
      M_BEQ:  e.word = {OP_JUMP, C_BEQ, rb};
      M_BNE:  e.word = {OP_JUMP, C_BNE, rb};
      M_BGE:  e.word = {OP_JUMP, C_BGE, rb};
      M_BGT:  e.word = {OP_JUMP, C_BGT, rb};
      M_BR:   e.word = {OP_JUMP, C_BR, rb};
      M_BOF:  e.word = {OP_JUMP, C_BOF, rb};
      M_ADD1: e.word = {OP_JUMP, C_ADD1, rb};
      M_ADD2: e.word = {OP_JUMP, C_ADD2, rb};
      M_SUB1: e.word = {OP_JUMP, C_SUB1, rb};
      M_XOR:  e.word = {OP_XOR, rd, ra, rb};
      M_AND:  e.word = {OP_AND, rd, ra, rb};
      default: e.ok = 1'b0;
    endcase
    return e;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO for encoded words (push/pop/wdata in; rdata head, full, empty out)
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
  assign rdata = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes mnemonic requests into 9-bit words and writes them to instruction memory
//   start/base_addr open a session; req_* is the valid/ready request stream;
//   im_we/im_ready/im_addr/im_wdata is the memory write port; busy/done/err/err_cnt/words_written report status
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_kind,
  input  logic              req_last,
  input  logic [1:0]        req_rd,
  input  logic [1:0]        req_ra,
  input  logic [1:0]        req_rb,
  input  logic [3:0]        req_imm,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [8:0]        im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W:0]   words_written
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state;
  enc_t enc;
  logic full, empty, accept, push, pop;
  logic [8:0] head;
  assign enc       = encode(req_kind, req_rd, req_ra, req_rb, req_imm);
  assign req_ready = state == LOAD && !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && enc.ok;
  assign im_we     = (state == LOAD || state == DRAIN) && !empty;
  assign pop       = im_we && im_ready;
  // stale RAM content is masked so the data bus reads 0 whenever nothing is offered
  assign im_wdata  = im_we ? head : '0;
  assign busy      = state != IDLE;
  instr_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(enc.word),
    .rdata(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      im_addr <= '0;
      words_written <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      err <= accept && !enc.ok;
      if (accept && !enc.ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      if (pop) begin
        im_addr <= im_addr + 1'b1;
        words_written <= words_written + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          im_addr <= base_addr;
          words_written <= '0;
        end
        LOAD: if (accept && req_last) state <= DRAIN;
        DRAIN: if (empty) begin
          state <= DONE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Reverse path of the 9-bit instruction decoder: accepts mnemonic-level requests over a valid/ready handshake.
- Encodes each request into the 9-bit ISA word and buffers it in a small FIFO.
- Writes the words into instruction memory at consecutive addresses from a programmable base.
- Used as the on-chip program loader and as an encode-side reference for decoder verification.

Parameters:
- ADDR_W, 8, instruction-memory address width; addresses wrap modulo 2^ADDR_W.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a load session; ignored unless IDLE.
- base_addr  in  ADDR_W  first write address, sampled on start.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_kind  in  5  mnemonic_t from the shared package.
- req_last  in  1  marks the final request of the session.
- req_rd / req_ra / req_rb  in  2 each  register fields.
- req_imm  in  4  unsigned immediate or shift amount.
- im_we  out  1  write strobe to instruction memory.
- im_ready  in  1  memory accepts the write this cycle.
- im_addr  out  ADDR_W  write address.
- im_wdata  out  9  encoded word.
- busy  out  1  high when not IDLE.
- done  out  1  1-cycle pulse when the session completes.
- err  out  1  1-cycle pulse on a rejected request.
- err_cnt  out  8  saturating count of rejected requests.
- words_written  out  ADDR_W+1  writes completed in the current session.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE and FIFO emptied.
  - All outputs 0: req_ready, im_we, im_addr, im_wdata, busy, done, err, err_cnt, words_written.
- Reset mid-session aborts immediately; no further im_we is asserted.
- State machine:
  - IDLE: on start, load addr=base_addr, clear words_written → LOAD. err_cnt is not cleared by start.
  - LOAD: req_ready = !fifo_full. When a request with req_last=1 is accepted → DRAIN.
  - DRAIN: req_ready=0. When FIFO is empty and no write is pending → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Encoding (opcode in bits [8:6]):
  - STR: 000, rd[5:4] is the data register, ra[3:2] is the base, imm[1:0].
  - LDR: 001, rd[5:4] dest, ra[3:2], imm[1:0].
  - MOV: 010, rd[5:4], imm[3:0].
  - SHR n: 011, rd[5:4], n[3:0].
  - SHL n: 011, rd[5:4], (16-n)[3:0], so SHL 8 encodes 4'b1000.
  - ADD/SUB/COPY/ABS: 100, subop {0,1,2,3}[5:4], ra[3:2], rb[1:0].
  - CMP: 101, 00, ra[3:2], rb[1:0].
  - Other JUMP-class (BLE, BLT, BEQ, BNE, BGE, BGT, BR, BOF, ADD1, ADD2, SUB1): 101, cond[5:2], rb[1:0].
  - cond codes: BLE 0100, BLT 0101, BEQ 0110, BNE 0111, BGE 1000, BGT 1010, BR 1011, ADD1 1100, ADD2 1101, SUB1 1110, BOF 1111.
  - XOR: 110, rd[5:4], ra[3:2], rb[1:0]. AND: 111, same fields.
  - Fields unused by a mnemonic are ignored.
- Rejection rules:
  - Reject if STR/LDR imm>3, SHR imm>7, SHL imm=0 or imm>8, or req_kind is undefined.
  - A rejected request is still consumed (handshake completes), is not pushed, pulses err in the next cycle, and increments err_cnt (saturates at 255).
  - A rejected req_last still moves LOAD → DRAIN.
- Datapath timing:
  - Encoding is combinational at the request side. A valid word is pushed on the accept edge.
  - im_we = (LOAD or DRAIN) && !fifo_empty. im_wdata is the FIFO head and im_addr is the current address.
  - On im_we && im_ready: pop, addr += 1 modulo 2^ADDR_W, words_written += 1.
  - A word accepted at edge k is visible on im_we in cycle k+1 at the earliest.
- FIFO:
  - Push and pop may occur on the same edge.
  - req_ready is low when full; there is no push-on-pop-when-full bypass.
  - With im_ready held at 1, throughput is 1 word/cycle.
- im_we and im_wdata/im_addr are held stable while im_ready=0.

Decomposition:
- Shared package isa_pkg holds opcode_t (3b), mnemonic_t (5b), saddto subop constants (2b), and jump cond constants (4b).
- isa_pkg is shared with the decoder so encode and decode cannot diverge.
- One sub-module: instr_fifo, a synchronous FIFO of width 9 and depth FIFO_DEPTH with full/empty flags and async active-low reset.

Test Plan:
- start with base_addr=0x10, then MOV rd=2 imm=9 with req_last=1 → one write at 0x10 of 9'h0A9; done pulses one cycle later; words_written=1.
- SHR rd=1 n=3; SHL rd=1 n=3; SHL rd=1 n=8 → 9'h0D3, 9'h0DD, 9'h0D8 at consecutive addresses.
- CMP ra=1 rb=2; BEQ rb=3; ADD1 rb=0 → 9'h146, 9'h15B, 9'h170.
- LDR imm=5, SHR imm=8, SHL imm=0, undefined kind → err pulses 4 times, no im_we, err_cnt=4; a following valid AND rd=3 ra=1 rb=2 writes 9'h1F6.
- FIFO_DEPTH=4 with im_ready held 0 and 6 requests offered → req_ready drops after 4 accepts; after im_ready=1, 6 writes to base..base+5 in order.
- Wrap and reset:
  - base_addr=0xFE with 3 words → addresses 0xFE, 0xFF, 0x00.
  - Assert rst_n=0 during DRAIN → im_we, busy, and FIFO contents clear immediately; no done pulse.
